// File: rtl/sw_rxbuf_mc_pac_if.sv
// Bus bundle for the multi-channel packet RX buffer: FrameLink inputs,
// shared read port, and per-channel NEWLEN/RELLEN/ERR handshakes.
interface sw_rxbuf_mc_pac_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CHANNELS   = 2,
  parameter int BLOCK_SIZE = 512
);
  localparam int REM_W  = $clog2(DATA_WIDTH / 8);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ADDR_W = $clog2(BLOCK_SIZE);

  logic [CHANNELS*DATA_WIDTH-1:0] RX_DATA;
  logic [CHANNELS*REM_W-1:0]      RX_REM;
  logic [CHANNELS-1:0]            RX_SOF_N;
  logic [CHANNELS-1:0]            RX_EOF_N;
  logic [CHANNELS-1:0]            RX_SRC_RDY_N;
  logic [CHANNELS-1:0]            RX_DST_RDY_N;
  logic [CHAN_W-1:0]              RD_CHAN;
  logic [ADDR_W-1:0]              RD_ADDR;
  logic                           RD_REQ;
  logic [DATA_WIDTH-1:0]          RD_DATA;
  logic                           RD_SRC_RDY;
  logic [CHANNELS*16-1:0]         RX_NEWLEN;
  logic [CHANNELS-1:0]            RX_NEWLEN_DV;
  logic [CHANNELS-1:0]            RX_NEWLEN_RDY;
  logic [CHANNELS*16-1:0]         RX_RELLEN;
  logic [CHANNELS-1:0]            RX_RELLEN_DV;
  logic [CHANNELS-1:0]            ERR;

  // Upstream FrameLink source plus software side.
  modport master (
    output RX_DATA, RX_REM, RX_SOF_N, RX_EOF_N, RX_SRC_RDY_N,
    input  RX_DST_RDY_N,
    output RD_CHAN, RD_ADDR, RD_REQ,
    input  RD_DATA, RD_SRC_RDY,
    input  RX_NEWLEN, RX_NEWLEN_DV,
    output RX_NEWLEN_RDY, RX_RELLEN, RX_RELLEN_DV,
    input  ERR
  );

  // The buffer itself.
  modport slave (
    input  RX_DATA, RX_REM, RX_SOF_N, RX_EOF_N, RX_SRC_RDY_N,
    output RX_DST_RDY_N,
    input  RD_CHAN, RD_ADDR, RD_REQ,
    output RD_DATA, RD_SRC_RDY,
    output RX_NEWLEN, RX_NEWLEN_DV,
    input  RX_NEWLEN_RDY, RX_RELLEN, RX_RELLEN_DV,
    output ERR
  );
endinterface

// File: rtl/sw_rxbuf_mc_pac.sv
// Multi-channel packet-mode SW RX buffer. Each channel owns a circular word
// buffer, a frame FSM, a free-space counter and a FIFO of completed frame
// byte lengths. Software reads stored words through one shared read port.
module sw_rxbuf_mc_pac #(
  parameter int DATA_WIDTH     = 64,
  parameter int CHANNELS       = 2,
  parameter int BLOCK_SIZE     = 512,
  parameter int LEN_FIFO_DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  sw_rxbuf_mc_pac_if.slave bus
);
  localparam int BPW    = DATA_WIDTH / 8;
  localparam int REM_W  = $clog2(BPW);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ADDR_W = $clog2(BLOCK_SIZE);
  localparam int LF_W   = $clog2(LEN_FIFO_DEPTH);
  localparam logic [15:0] BPW16 = 16'(BPW);

  typedef enum logic {S_IDLE, S_DATA} state_t;

  // Words needed to cover a released byte count (rounded up).
  function automatic logic [17:0] ceil_words(input logic [15:0] bytes);
    logic [17:0] t;
    t = 18'(bytes) + 18'(BPW - 1);
    return t >> REM_W;
  endfunction

  // Free-space count clamped at the buffer capacity.
  function automatic logic [ADDR_W:0] sat_free(input logic [17:0] s);
    if (s > 18'(BLOCK_SIZE)) return (ADDR_W+1)'(BLOCK_SIZE);
    else return s[ADDR_W:0];
  endfunction

  logic [CHANNELS*DATA_WIDTH-1:0] rd_words_p1;
  logic [CHANNELS-1:0]            dst_rdy_n_w;
  logic [CHANNELS-1:0]            newlen_dv_w;
  logic [CHANNELS*16-1:0]         newlen_w;
  logic [CHANNELS-1:0]            err_w;
  logic [CHAN_W-1:0]              rd_chan_p1;
  logic                           rd_vld_p1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [BLOCK_SIZE];
    logic [15:0]           lfifo [LEN_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rd_word_p1;
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W:0]       free_cnt;
    logic [15:0]           byte_cnt, cnt_d;
    logic [LF_W-1:0]       lf_rp, lf_wp;
    logic [LF_W:0]         lf_cnt;
    logic                  err_q;
    state_t                state_q, state_d;
    logic                  sof, eof, rdy, xfer, store, drop;
    logic                  push_close, push_eof, pop, rel_over, lf_dv;
    logic [1:0]            need_room;
    logic [LF_W+1:0]       room_sum;
    logic [15:0]           rem_len, len_eof;
    logic [17:0]           free_sum;

    assign sof     = ~bus.RX_SOF_N[c];
    assign eof     = ~bus.RX_EOF_N[c];
    assign rem_len = 16'(bus.RX_REM[c*REM_W +: REM_W]) + 16'd1;

    // A SOF inside a frame closes the old frame, so it needs a FIFO slot too.
    assign need_room = {1'b0, (state_q == S_DATA) && sof} + {1'b0, eof};
    assign room_sum  = (LF_W+2)'(lf_cnt) + (LF_W+2)'(need_room);
    assign rdy  = !RESET && (free_cnt != '0) &&
                  (room_sum <= (LF_W+2)'(LEN_FIFO_DEPTH));
    assign xfer = rdy && ~bus.RX_SRC_RDY_N[c];

    assign lf_dv = (lf_cnt != '0);
    assign pop   = lf_dv && bus.RX_NEWLEN_RDY[c];

    assign free_sum = 18'(free_cnt) - 18'(store) +
                      (bus.RX_RELLEN_DV[c] ? ceil_words(bus.RX_RELLEN[c*16 +: 16]) : 18'd0);
    assign rel_over = free_sum > 18'(BLOCK_SIZE);

    // Frame FSM: decide store/drop, length pushes and the running byte count.
    always_comb begin
      state_d    = state_q;
      cnt_d      = byte_cnt;
      store      = 1'b0;
      drop       = 1'b0;
      push_close = 1'b0;
      push_eof   = 1'b0;
      len_eof    = rem_len;
      if (xfer) begin
        unique case (state_q)
          S_IDLE: begin
            if (sof) begin
              store = 1'b1;
              if (eof) begin
                push_eof = 1'b1;
              end else begin
                cnt_d   = BPW16;
                state_d = S_DATA;
              end
            end else begin
              drop = 1'b1;
            end
          end
          S_DATA: begin
            store = 1'b1;
            if (sof) begin
              push_close = 1'b1;
              if (eof) begin
                push_eof = 1'b1;
                state_d  = S_IDLE;
              end else begin
                cnt_d = BPW16;
              end
            end else if (eof) begin
              push_eof = 1'b1;
              len_eof  = byte_cnt + rem_len;
              state_d  = S_IDLE;
            end else begin
              cnt_d = byte_cnt + BPW16;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Control state: FSM, pointers, free space, length FIFO occupancy, sticky error.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        state_q  <= S_IDLE;
        byte_cnt <= '0;
        wr_ptr   <= '0;
        free_cnt <= (ADDR_W+1)'(BLOCK_SIZE);
        lf_rp    <= '0;
        lf_wp    <= '0;
        lf_cnt   <= '0;
        err_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        byte_cnt <= cnt_d;
        if (store) wr_ptr <= wr_ptr + ADDR_W'(1);
        free_cnt <= sat_free(free_sum);
        lf_wp    <= lf_wp + LF_W'(push_close) + LF_W'(push_eof);
        if (pop) lf_rp <= lf_rp + LF_W'(1);
        lf_cnt   <= lf_cnt + (LF_W+1)'(push_close) + (LF_W+1)'(push_eof) - (LF_W+1)'(pop);
        if (drop || push_close || rel_over) err_q <= 1'b1;
      end
    end

    // ---- stage p0 -> p1: buffer/FIFO writes and registered read word ----
    always_ff @(posedge CLK) begin
      if (store) mem[wr_ptr] <= bus.RX_DATA[c*DATA_WIDTH +: DATA_WIDTH];
      if (push_close) lfifo[lf_wp] <= byte_cnt;
      if (push_eof) lfifo[lf_wp + LF_W'(push_close)] <= len_eof;
      if (bus.RD_REQ) rd_word_p1 <= mem[bus.RD_ADDR];
    end

    assign rd_words_p1[c*DATA_WIDTH +: DATA_WIDTH] = rd_word_p1;
    assign dst_rdy_n_w[c]      = ~rdy;
    assign newlen_dv_w[c]      = lf_dv;
    assign newlen_w[c*16 +: 16] = lf_dv ? lfifo[lf_rp] : 16'd0;
    assign err_w[c]            = err_q;
  end

  // Read valid follows a request by exactly one cycle.
  always_ff @(posedge CLK) begin
    if (RESET) rd_vld_p1 <= 1'b0;
    else       rd_vld_p1 <= bus.RD_REQ;
  end

  // Remember which channel the pending read addressed.
  always_ff @(posedge CLK) begin
    if (bus.RD_REQ) rd_chan_p1 <= bus.RD_CHAN;
  end

  assign bus.RD_DATA      = rd_vld_p1 ? rd_words_p1[rd_chan_p1*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.RD_SRC_RDY   = rd_vld_p1;
  assign bus.RX_DST_RDY_N = dst_rdy_n_w;
  assign bus.RX_NEWLEN_DV = newlen_dv_w;
  assign bus.RX_NEWLEN    = newlen_w;
  assign bus.ERR          = err_w;
endmodule

// File: tb/tb_sw_rxbuf_mc_pac.sv
// Directed bench for sw_rxbuf_mc_pac with 2 channels, 64-bit words,
// 512-word buffers and 16-entry length FIFOs.
module tb_sw_rxbuf_mc_pac;
  localparam int DW = 64;
  localparam int CH = 2;
  localparam int BS = 512;
  localparam int LD = 16;

  logic CLK = 1'b0;
  logic RESET;
  int   n_cmp;
  int   n_fail;

  sw_rxbuf_mc_pac_if #(.DATA_WIDTH(DW), .CHANNELS(CH), .BLOCK_SIZE(BS)) bus ();

  sw_rxbuf_mc_pac #(.DATA_WIDTH(DW), .CHANNELS(CH), .BLOCK_SIZE(BS), .LEN_FIFO_DEPTH(LD)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs;
    bus.RX_DATA       = '0;
    bus.RX_REM        = '0;
    bus.RX_SOF_N      = '1;
    bus.RX_EOF_N      = '1;
    bus.RX_SRC_RDY_N  = '1;
    bus.RD_CHAN       = '0;
    bus.RD_ADDR       = '0;
    bus.RD_REQ        = 1'b0;
    bus.RX_NEWLEN_RDY = '0;
    bus.RX_RELLEN     = '0;
    bus.RX_RELLEN_DV  = '0;
  endtask

  task automatic drive(input int ch, input logic [63:0] d, input bit sof, input bit eof,
                       input logic [2:0] rem);
    bus.RX_DATA[ch*DW +: DW] = d;
    bus.RX_REM[ch*3 +: 3]    = rem;
    bus.RX_SOF_N[ch]         = ~sof;
    bus.RX_EOF_N[ch]         = ~eof;
    bus.RX_SRC_RDY_N[ch]     = 1'b0;
  endtask

  task automatic stop_ch(input int ch);
    bus.RX_SRC_RDY_N[ch] = 1'b1;
    bus.RX_SOF_N[ch]     = 1'b1;
    bus.RX_EOF_N[ch]     = 1'b1;
  endtask

  // One word that must be accepted immediately.
  task automatic send(input int ch, input logic [63:0] d, input bit sof, input bit eof,
                      input logic [2:0] rem);
    drive(ch, d, sof, eof, rem);
    #1;
    check($sformatf("dst_rdy_n_ch%0d", ch), 64'(bus.RX_DST_RDY_N[ch]), 64'd0);
    tick;
  endtask

  task automatic rd_check(input string tag, input int ch, input int addr, input logic [63:0] exp);
    bus.RD_REQ  = 1'b1;
    bus.RD_CHAN = 1'(ch);
    bus.RD_ADDR = 9'(addr);
    tick;
    bus.RD_REQ = 1'b0;
    check({tag, "_vld"}, 64'(bus.RD_SRC_RDY), 64'd1);
    check(tag, bus.RD_DATA, exp);
  endtask

  task automatic pop(input int ch);
    bus.RX_NEWLEN_RDY[ch] = 1'b1;
    tick;
    bus.RX_NEWLEN_RDY[ch] = 1'b0;
  endtask

  task automatic release_bytes(input int ch, input int bytes);
    bus.RX_RELLEN[ch*16 +: 16] = 16'(bytes);
    bus.RX_RELLEN_DV[ch]       = 1'b1;
    tick;
    bus.RX_RELLEN_DV[ch] = 1'b0;
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    tick;
    tick;
    RESET = 1'b0;
    idle_inputs();
    tick;
  endtask

  function automatic logic [63:0] pat(input int c, input int k, input int j);
    return {8'hA0 + 8'(c), 8'(k), 16'(j), 16'hBEEF, 8'(c), 8'(k)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int l0, l1;
    n_cmp  = 0;
    n_fail = 0;
    idle_inputs();
    RESET = 1'b1;
    repeat (3) tick;

    // Reset state
    check("rst_dst_rdy_n", 64'(bus.RX_DST_RDY_N), 64'h3);
    check("rst_rd_src_rdy", 64'(bus.RD_SRC_RDY), 64'd0);
    check("rst_rd_data", bus.RD_DATA, 64'd0);
    check("rst_newlen_dv", 64'(bus.RX_NEWLEN_DV), 64'd0);
    check("rst_newlen", 64'(bus.RX_NEWLEN), 64'd0);
    check("rst_err", 64'(bus.ERR), 64'd0);
    RESET = 1'b0;
    tick;
    check("post_rst_dst_rdy_n", 64'(bus.RX_DST_RDY_N), 64'h0);

    // T1: three-word frame on ch0, REM=4 -> 8+8+5 = 21 bytes
    send(0, 64'h1111_0000_0000_0001, 1, 0, 3'd0);
    send(0, 64'h2222_0000_0000_0002, 0, 0, 3'd0);
    check("t1_no_len_midframe", 64'(bus.RX_NEWLEN_DV[0]), 64'd0);
    send(0, 64'h3333_0000_0000_0003, 0, 1, 3'd4);
    stop_ch(0);
    check("t1_newlen_dv", 64'(bus.RX_NEWLEN_DV[0]), 64'd1);
    check("t1_newlen", 64'(bus.RX_NEWLEN[15:0]), 64'd21);
    rd_check("t1_rd0", 0, 0, 64'h1111_0000_0000_0001);
    rd_check("t1_rd1", 0, 1, 64'h2222_0000_0000_0002);
    rd_check("t1_rd2", 0, 2, 64'h3333_0000_0000_0003);
    tick;
    check("t1_rd_idle", 64'(bus.RD_SRC_RDY), 64'd0);
    pop(0);
    check("t1_popped_dv", 64'(bus.RX_NEWLEN_DV[0]), 64'd0);

    // T2: fill ch1, stall, release 64 bytes -> 8 more words, stall again
    for (int i = 0; i < 512; i++) send(1, {32'hC1, 32'(i)}, i == 0, 0, 3'd0);
    drive(1, {32'hC1, 32'd512}, 0, 0, 3'd0);
    #1;
    check("t2_full_stall", 64'(bus.RX_DST_RDY_N[1]), 64'd1);
    check("t2_ch0_unaffected", 64'(bus.RX_DST_RDY_N[0]), 64'd0);
    tick;
    release_bytes(1, 64);
    check("t2_after_release", 64'(bus.RX_DST_RDY_N[1]), 64'd0);
    for (int i = 512; i < 520; i++) send(1, {32'hC1, 32'(i)}, 0, 0, 3'd0);
    drive(1, {32'hC1, 32'd520}, 0, 0, 3'd0);
    #1;
    check("t2_restall", 64'(bus.RX_DST_RDY_N[1]), 64'd1);
    tick;
    rd_check("t2_rd_wrap0", 1, 0, {32'hC1, 32'd512});
    rd_check("t2_rd_wrap7", 1, 7, {32'hC1, 32'd519});
    rd_check("t2_rd_old8", 1, 8, {32'hC1, 32'd8});
    rd_check("t2_rd_511", 1, 511, {32'hC1, 32'd511});
    release_bytes(1, 8);
    send(1, {32'hC1, 32'd520}, 0, 1, 3'd7);
    stop_ch(1);
    check("t2_newlen", 64'(bus.RX_NEWLEN[31:16]), 64'd4168);
    pop(1);

    // T3: 16 single-word frames fill the length FIFO; the 17th EOF stalls
    for (int i = 0; i < 16; i++) send(0, {32'hF3, 32'(i)}, 1, 1, 3'(i % 8));
    drive(0, {32'hF3, 32'd16}, 1, 1, 3'd0);
    #1;
    check("t3_fifo_full_stall", 64'(bus.RX_DST_RDY_N[0]), 64'd1);
    check("t3_head", 64'(bus.RX_NEWLEN[15:0]), 64'd1);
    tick;
    bus.RX_NEWLEN_RDY[0] = 1'b1;
    tick;
    bus.RX_NEWLEN_RDY[0] = 1'b0;
    check("t3_room_after_pop", 64'(bus.RX_DST_RDY_N[0]), 64'd0);
    tick;
    stop_ch(0);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("t3_len%0d", i), 64'(bus.RX_NEWLEN[15:0]), 64'((i % 8) + 1));
      pop(0);
    end
    check("t3_drained", 64'(bus.RX_NEWLEN_DV[0]), 64'd0);

    // T4: both channels stream 100-word frames together, wrapping the buffer
    do_reset();
    base = 0;
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 100; j++) begin
        drive(0, pat(0, k, j), j == 0, j == 99, 3'(k % 8));
        drive(1, pat(1, k, j), j == 0, j == 99, 3'(7 - (k % 8)));
        #1;
        check("t4_rdy", 64'(bus.RX_DST_RDY_N), 64'd0);
        tick;
      end
      stop_ch(0);
      stop_ch(1);
      l0 = 792 + (k % 8) + 1;
      l1 = 792 + 8 - (k % 8);
      check($sformatf("t4_dv_f%0d", k), 64'(bus.RX_NEWLEN_DV), 64'h3);
      check($sformatf("t4_len0_f%0d", k), 64'(bus.RX_NEWLEN[15:0]), 64'(l0));
      check($sformatf("t4_len1_f%0d", k), 64'(bus.RX_NEWLEN[31:16]), 64'(l1));
      rd_check($sformatf("t4_c0_first_f%0d", k), 0, base % BS, pat(0, k, 0));
      rd_check($sformatf("t4_c0_last_f%0d", k), 0, (base + 99) % BS, pat(0, k, 99));
      rd_check($sformatf("t4_c1_first_f%0d", k), 1, base % BS, pat(1, k, 0));
      rd_check($sformatf("t4_c1_last_f%0d", k), 1, (base + 99) % BS, pat(1, k, 99));
      bus.RX_NEWLEN_RDY = 2'b11;
      tick;
      bus.RX_NEWLEN_RDY = 2'b00;
      bus.RX_RELLEN     = {16'(l1), 16'(l0)};
      bus.RX_RELLEN_DV  = 2'b11;
      tick;
      bus.RX_RELLEN_DV  = 2'b00;
      base += 100;
    end

    // T5: word without SOF is dropped with ERR; over-release saturates free
    do_reset();
    drive(1, 64'hBAD0_BAD0_BAD0_BAD0, 0, 1, 3'd0);
    #1;
    check("t5_nosof_accepted", 64'(bus.RX_DST_RDY_N[1]), 64'd0);
    tick;
    stop_ch(1);
    check("t5_err_nosof", 64'(bus.ERR), 64'h2);
    tick;
    check("t5_no_newlen", 64'(bus.RX_NEWLEN_DV), 64'd0);
    send(1, 64'h600D_600D_600D_600D, 1, 1, 3'd2);
    stop_ch(1);
    check("t5_good_len", 64'(bus.RX_NEWLEN[31:16]), 64'd3);
    rd_check("t5_good_at0", 1, 0, 64'h600D_600D_600D_600D);
    pop(1);
    release_bytes(0, 4096);
    check("t5_err_overrelease", 64'(bus.ERR), 64'h3);
    for (int i = 0; i < 512; i++) send(0, {32'h55, 32'(i)}, i == 0, 0, 3'd0);
    drive(0, {32'h55, 32'd512}, 0, 0, 3'd0);
    #1;
    check("t5_saturated_capacity", 64'(bus.RX_DST_RDY_N[0]), 64'd1);
    tick;
    stop_ch(0);

    // T6: reset mid-frame discards it; SOF inside a frame closes it with ERR
    do_reset();
    send(0, 64'hAAAA, 1, 0, 3'd0);
    send(0, 64'hBBBB, 0, 0, 3'd0);
    drive(0, 64'hCCCC, 0, 0, 3'd0);
    RESET = 1'b1;
    #1;
    check("t6_rst_dst_rdy_n", 64'(bus.RX_DST_RDY_N), 64'h3);
    tick;
    check("t6_rst_no_newlen", 64'(bus.RX_NEWLEN_DV), 64'd0);
    tick;
    RESET = 1'b0;
    stop_ch(0);
    tick;
    check("t6_err_clear", 64'(bus.ERR), 64'd0);
    send(0, 64'hDDDD, 1, 1, 3'd3);
    stop_ch(0);
    check("t6_len", 64'(bus.RX_NEWLEN[15:0]), 64'd4);
    rd_check("t6_addr0", 0, 0, 64'hDDDD);
    pop(0);
    send(0, 64'hEEEE, 1, 0, 3'd0);
    send(0, 64'hFFFF, 1, 1, 3'd1);
    stop_ch(0);
    check("t6_err_sof_in_data", 64'(bus.ERR), 64'h1);
    check("t6_closed_len", 64'(bus.RX_NEWLEN[15:0]), 64'd8);
    pop(0);
    check("t6_new_len", 64'(bus.RX_NEWLEN[15:0]), 64'd2);
    pop(0);
    check("t6_fifo_empty", 64'(bus.RX_NEWLEN_DV[0]), 64'd0);
    rd_check("t6_addr1", 0, 1, 64'hEEEE);
    rd_check("t6_addr2", 0, 2, 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
